// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes and width helpers for the pipelined ALU
package alu_pkg;

   // Width of the op field carried on the issue interface.
   localparam int OP_W = 4;

   localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
   localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
   localparam logic [OP_W-1:0] OP_XOR  = 4'b0010;
   localparam logic [OP_W-1:0] OP_SLT  = 4'b0011;
   localparam logic [OP_W-1:0] OP_SLTU = 4'b0100;
   localparam logic [OP_W-1:0] OP_SLL  = 4'b0101;
   localparam logic [OP_W-1:0] OP_SRL  = 4'b0110;
   localparam logic [OP_W-1:0] OP_SRA  = 4'b0111;
   localparam logic [OP_W-1:0] OP_AND  = 4'b1110;
   localparam logic [OP_W-1:0] OP_OR   = 4'b1111;

   // Number of low-order bits of operand B used as a shift amount.
   function automatic int shamt_width(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/alu_pipe_stage.sv
// rtl/alu_pipe_stage.sv - one valid/ready register slice of the ALU pipeline
module alu_pipe_stage #(
   parameter int DW = 65
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [DW-1:0] i_data,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [DW-1:0] o_data
);

   logic          r_valid;
   logic [DW-1:0] r_data;

   // The slice can take a new entry when empty or when its content leaves this cycle.
   assign o_ready = ~r_valid | i_ready;
   assign o_valid = r_valid;
   assign o_data  = r_data;

   // Load valid on every ready cycle; data only moves when upstream actually holds something.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (o_ready) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_data <= i_data;
         end
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - pipelined integer ALU with word mode, zero flag and valid/ready handshake
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH   = 64,
   parameter int LATENCY = 1,
   parameter int WORD_EN = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [OP_W-1:0]  op,
   input  logic             word,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] res,
   output logic             zero,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int SHW     = shamt_width(WIDTH);
   localparam bit WORD_OK = (WORD_EN != 0) && (WIDTH == 64);
   localparam int DW      = WIDTH + 1;

   // Sign-extend a 32-bit word result to the datapath width.
   function automatic logic [WIDTH-1:0] sext32(input logic [31:0] v);
      logic [63:0] t;
      t = {{32{v[31]}}, v};
      return t[WIDTH-1:0];
   endfunction

   logic             w_word;
   logic [SHW-1:0]   w_shamt;
   logic [4:0]       w_wshamt;

   logic [WIDTH-1:0] w_add;
   logic [WIDTH-1:0] w_sub;
   logic [WIDTH-1:0] w_sll;
   logic [WIDTH-1:0] w_srl;
   logic [WIDTH-1:0] w_sra;
   logic             w_lts;
   logic             w_ltu;

   logic [31:0]      w_wadd;
   logic [31:0]      w_wsub;
   logic [31:0]      w_wsll;
   logic [31:0]      w_wsrl;
   logic [31:0]      w_wsra;

   logic [WIDTH-1:0] w_res;
   logic             w_zero;

   // Word mode only exists on a 64-bit datapath that has it enabled.
   assign w_word   = word & WORD_OK;
   assign w_shamt  = in2[SHW-1:0];
   assign w_wshamt = in2[4:0];

   // Full-width arithmetic, compare and shift candidates.
   assign w_add = in1 + in2;
   assign w_sub = in1 + ~in2 + {{(WIDTH-1){1'b0}}, 1'b1};
   assign w_sll = in1 << w_shamt;
   assign w_srl = in1 >> w_shamt;
   assign w_sra = $signed(in1) >>> w_shamt;
   assign w_lts = $signed(in1) < $signed(in2);
   assign w_ltu = in1 < in2;

   // 32-bit word candidates; SRL shifts logically before the sign extension.
   assign w_wadd = in1[31:0] + in2[31:0];
   assign w_wsub = in1[31:0] + ~in2[31:0] + 32'd1;
   assign w_wsll = in1[31:0] << w_wshamt;
   assign w_wsrl = in1[31:0] >> w_wshamt;
   assign w_wsra = $signed(in1[31:0]) >>> w_wshamt;

   // Select the result for the issued op; unknown codes produce zero and still flow.
   always_comb begin
      w_res = '0;
      case (op)
         OP_ADD:  w_res = w_word ? sext32(w_wadd) : w_add;
         OP_SUB:  w_res = w_word ? sext32(w_wsub) : w_sub;
         OP_XOR:  w_res = in1 ^ in2;
         OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_lts};
         OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, w_ltu};
         OP_SLL:  w_res = w_word ? sext32(w_wsll) : w_sll;
         OP_SRL:  w_res = w_word ? sext32(w_wsrl) : w_srl;
         OP_SRA:  w_res = w_word ? sext32(w_wsra) : w_sra;
         OP_AND:  w_res = in1 & in2;
         OP_OR:   w_res = in1 | in2;
         default: w_res = '0;
      endcase
   end

   assign w_zero = (w_res == '0);

   // Handshake chain: index 0 is the issue side, index LATENCY the writeback side.
   logic [LATENCY:0] w_valid;
   logic [LATENCY:0] w_ready;
   logic [DW-1:0]    w_data [LATENCY+1];

   assign w_valid[0]       = in_valid;
   assign w_data[0]        = {w_zero, w_res};
   assign w_ready[LATENCY] = out_ready;
   assign in_ready         = w_ready[0];

   for (genvar g = 0; g < LATENCY; g++) begin : g_stage
      alu_pipe_stage #(
         .DW(DW)
      ) u_stage (
         .clk    (clk),
         .rstn   (rstn),
         .i_valid(w_valid[g]),
         .o_ready(w_ready[g]),
         .i_data (w_data[g]),
         .o_valid(w_valid[g+1]),
         .i_ready(w_ready[g+1]),
         .o_data (w_data[g+1])
      );
   end

   assign out_valid = w_valid[LATENCY];
   assign res       = w_data[LATENCY][WIDTH-1:0];
   assign zero      = w_data[LATENCY][WIDTH];

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe at LATENCY 1 and 3
module tb_alu_pipe;
   import alu_pkg::*;

   logic        clk;
   logic        rstn;
   logic [63:0] in1;
   logic [63:0] in2;
   logic [3:0]  op;
   logic        word;

   logic        in_valid1, in_ready1, out_valid1, out_ready1, zero1;
   logic [63:0] res1;
   logic        in_valid3, in_ready3, out_valid3, out_ready3, zero3;
   logic [63:0] res3;

   logic        rnd_mode;
   logic        ord_force1;
   logic        ord_force3;

   int          n_cmp;
   int          n_bad;
   logic [64:0] q1[$];
   logic [64:0] q3[$];

   alu_pipe #(.WIDTH(64), .LATENCY(1), .WORD_EN(1)) u_dut1 (
      .clk(clk), .rstn(rstn), .in1(in1), .in2(in2), .op(op), .word(word),
      .in_valid(in_valid1), .in_ready(in_ready1), .res(res1), .zero(zero1),
      .out_valid(out_valid1), .out_ready(out_ready1)
   );

   alu_pipe #(.WIDTH(64), .LATENCY(3), .WORD_EN(1)) u_dut3 (
      .clk(clk), .rstn(rstn), .in1(in1), .in2(in2), .op(op), .word(word),
      .in_valid(in_valid3), .in_ready(in_ready3), .res(res3), .zero(zero3),
      .out_valid(out_valid3), .out_ready(out_ready3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   // Consumer side: random or forced out_ready, updated at each falling edge.
   initial begin
      out_ready1 = 1'b1;
      out_ready3 = 1'b1;
      forever begin
         @(negedge clk);
         out_ready1 = rnd_mode ? 1'($urandom_range(0, 1)) : ord_force1;
         out_ready3 = rnd_mode ? 1'($urandom_range(0, 1)) : ord_force3;
      end
   end

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic [3:0] o, input logic w);
      logic [63:0]        r;
      logic [31:0]        t;
      logic signed [63:0] sa;
      logic signed [31:0] st;
      logic               sx;
      r  = 64'd0;
      t  = 32'd0;
      sa = a;
      st = a[31:0];
      sx = 1'b0;
      case (o)
         4'd0:  if (w) begin t = a[31:0] + b[31:0]; sx = 1'b1; end else r = a + b;
         4'd1:  if (w) begin t = a[31:0] - b[31:0]; sx = 1'b1; end else r = a - b;
         4'd2:  r = a ^ b;
         4'd3:  r = (sa < $signed(b)) ? 64'd1 : 64'd0;
         4'd4:  r = (a < b) ? 64'd1 : 64'd0;
         4'd5:  if (w) begin t = a[31:0] << b[4:0]; sx = 1'b1; end else r = a << b[5:0];
         4'd6:  if (w) begin t = a[31:0] >> b[4:0]; sx = 1'b1; end else r = a >> b[5:0];
         4'd7:  if (w) begin t = st >>> b[4:0]; sx = 1'b1; end else r = sa >>> b[5:0];
         4'd14: r = a & b;
         4'd15: r = a | b;
         default: r = 64'd0;
      endcase
      if (sx) r = {{32{t[31]}}, t};
      return {(r == 64'd0), r};
   endfunction

   task automatic issue(input int sel, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] o, input logic w, input logic [64:0] exp);
      int t;
      @(negedge clk);
      in1 = a; in2 = b; op = o; word = w;
      if (sel == 1) in_valid1 = 1'b1; else in_valid3 = 1'b1;
      #1;
      t = 0;
      while (!((sel == 1) ? in_ready1 : in_ready3) && t < 200) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (t >= 200) begin
         n_cmp++; n_bad++;
         $display("FAIL issue_timeout: got in_ready=0 expected in_ready=1");
      end else if (sel == 1) q1.push_back(exp);
      else q3.push_back(exp);
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
      in_valid3 = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((q1.size() != 0 || q3.size() != 0) && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 1000) begin
         n_cmp++; n_bad++;
         $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", q1.size(), q3.size());
      end
   endtask

   // Monitor for the LATENCY=1 instance: pop and compare on each transfer, check hold while stalled.
   logic        stall1;
   logic [64:0] held1;
   always @(negedge clk) begin
      #2;
      if (rstn && out_valid1) begin
         if (stall1) chk("stable1", {zero1, res1}, held1);
         if (out_ready1) begin
            if (q1.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected1: got %h expected no output", {zero1, res1});
            end else chk("res1", {zero1, res1}, q1.pop_front());
         end
         stall1 = !out_ready1;
         held1  = {zero1, res1};
      end else stall1 = 1'b0;
   end

   // Monitor for the LATENCY=3 instance.
   logic        stall3;
   logic [64:0] held3;
   always @(negedge clk) begin
      #2;
      if (rstn && out_valid3) begin
         if (stall3) chk("stable3", {zero3, res3}, held3);
         if (out_ready3) begin
            if (q3.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected3: got %h expected no output", {zero3, res3});
            end else chk("res3", {zero3, res3}, q3.pop_front());
         end
         stall3 = !out_ready3;
         held3  = {zero3, res3};
      end else stall3 = 1'b0;
   end

   initial begin
      logic [63:0] ra, rb;
      logic [3:0]  rop;
      logic        rw;
      int          acc;

      n_cmp = 0; n_bad = 0;
      stall1 = 1'b0; stall3 = 1'b0; held1 = '0; held3 = '0;
      rnd_mode = 1'b0; ord_force1 = 1'b1; ord_force3 = 1'b1;
      rstn = 1'b0;
      in1 = '0; in2 = '0; op = '0; word = 1'b0;
      in_valid1 = 1'b0; in_valid3 = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid1", 65'(out_valid1), 65'd0);
      chk("rst_res1", {zero1, res1}, 65'd0);
      chk("rst_ready1", 65'(in_ready1), 65'd1);
      chk("rst_valid3", 65'(out_valid3), 65'd0);
      chk("rst_res3", {zero3, res3}, 65'd0);
      chk("rst_ready3", 65'(in_ready3), 65'd1);
      @(negedge clk);
      rstn = 1'b1;

      // Directed vectors on the single-stage instance.
      issue(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD, 1'b0, {1'b1, 64'h0});
      @(negedge clk);
      #1;
      chk("lat1_valid", 65'(out_valid1), 65'd1);
      issue(1, 64'd5, 64'd7, OP_SUB, 1'b0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
      issue(1, 64'h8000_0000_0000_0000, 64'd1, OP_SLT, 1'b0, {1'b0, 64'd1});
      issue(1, 64'h8000_0000_0000_0000, 64'd1, OP_SLTU, 1'b0, {1'b1, 64'd0});
      issue(1, 64'h7FFF_FFFF, 64'd1, OP_ADD, 1'b1, {1'b0, 64'hFFFF_FFFF_8000_0000});
      issue(1, 64'h8000_0000_0000_0000, 64'h43, OP_SRA, 1'b0, {1'b0, 64'hF000_0000_0000_0000});
      issue(1, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, OP_XOR, 1'b1,
            {1'b0, 64'hF00F_F00F_F00F_F00F});
      issue(1, 64'hF0F0, 64'hFF00, OP_AND, 1'b0, {1'b0, 64'hF000});
      issue(1, 64'hF0F0, 64'hFF00, OP_OR, 1'b0, {1'b0, 64'hFFF0});
      issue(1, 64'd5, 64'd3, 4'b1000, 1'b0, {1'b1, 64'd0});
      issue(1, 64'd1, 64'h41, OP_SLL, 1'b0, {1'b0, 64'd2});
      issue(1, 64'd1, 64'd31, OP_SLL, 1'b1, {1'b0, 64'hFFFF_FFFF_8000_0000});
      issue(1, 64'hFFFF_FFFF_8000_0000, 64'd1, OP_SRL, 1'b1, {1'b0, 64'h4000_0000});
      issue(1, 64'h8000_0000_0000_0000, 64'd63, OP_SRL, 1'b0, {1'b0, 64'd1});
      issue(1, 64'd0, 64'd1, OP_SUB, 1'b1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
      issue(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, OP_SLT, 1'b1, {1'b0, 64'd1});
      issue(1, 64'h8000_0000, 64'd4, OP_SRA, 1'b1, {1'b0, 64'hFFFF_FFFF_F800_0000});
      drain();

      // Back-pressure on the three-stage instance: fills to three, then drains in order without gaps.
      ord_force3 = 1'b0;
      acc = 0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         in1 = 64'(i); in2 = 64'(i); op = OP_ADD; word = 1'b0; in_valid3 = 1'b1;
         #1;
         if (!in_ready3) break;
         q3.push_back({1'b0, 64'(2 * i)});
         acc++;
      end
      chk("bp_accepted", 65'(acc), 65'd3);
      chk("bp_in_ready", 65'(in_ready3), 65'd0);
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("bp_hold_ready", 65'(in_ready3), 65'd0);
      end
      ord_force3 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         chk("bp_no_gap", 65'(out_valid3), 65'd1);
         if (k == 0) begin
            chk("bp_accept_drain", 65'(in_ready3), 65'd1);
            q3.push_back({1'b0, 64'd8});
         end else if (k == 1) begin
            in1 = 64'd5; in2 = 64'd5;
            #1;
            chk("bp_accept5", 65'(in_ready3), 65'd1);
            q3.push_back({1'b0, 64'd10});
         end else if (k == 2) begin
            in_valid3 = 1'b0;
         end
      end
      drain();

      // Asynchronous reset with two ops in flight.
      ord_force3 = 1'b0;
      issue(3, 64'd1, 64'd1, OP_ADD, 1'b0, {1'b0, 64'd2});
      issue(3, 64'd2, 64'd2, OP_ADD, 1'b0, {1'b0, 64'd4});
      repeat (3) @(negedge clk);
      #1;
      chk("pre_rst_valid", 65'(out_valid3), 65'd1);
      @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_valid", 65'(out_valid3), 65'd0);
      chk("arst_res", {zero3, res3}, 65'd0);
      chk("arst_ready", 65'(in_ready3), 65'd1);
      q3.delete();
      @(negedge clk);
      #1;
      rstn = 1'b1;
      ord_force3 = 1'b1;
      repeat (6) begin
         @(negedge clk);
         #1;
         chk("post_rst_idle", 65'(out_valid3), 65'd0);
      end

      // Random ops against the reference model with random back-pressure.
      rnd_mode = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         ra  = {$urandom, $urandom};
         rb  = {$urandom, $urandom};
         rop = 4'($urandom_range(0, 15));
         rw  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) rb = rb & 64'hFF;
         if ($urandom_range(0, 7) == 0) rb = ra;
         issue((n < 500) ? 1 : 3, ra, rb, rop, rw, model(ra, rb, rop, rw));
      end
      rnd_mode = 1'b0;
      ord_force1 = 1'b1;
      ord_force3 = 1'b1;
      drain();
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
